// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - instruction, data and RAM bus bundle for mem_arbiter
// slave is the arbiter's view; master is the requester/RAM environment view.
interface mem_arbiter_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        iwait;

  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] dload;
  logic        dwait;

  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;

  logic        timeout_err;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore, timeout_err
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore, timeout_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port RAM arbiter between instruction and data requesters
// Optional fairness (MEM_ARBITER_FAIR_EN) bounds consecutive data grants while iREN waits.
module mem_arbiter #(
  parameter int TIMEOUT    = 255,
  parameter int FAIR_LIMIT = 4
) (
  input  logic         CLK,
  input  logic         RST,
  mem_arbiter_if.slave bus
);

  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;
  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  typedef enum logic [1:0] {IDLE, IGRANT, DGRANT} state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic          err_q;

  logic        d_req;
  logic        ram_done;
  logic        tmo;
  logic        i_act;
  logic        d_act;
  logic        i_done;
  logic        d_done;
  logic [31:0] ld_val;
  logic        fair_force;

  assign d_req    = bus.dREN | bus.dWEN;
  assign ram_done = (bus.ramstate == RS_ACCESS) || (bus.ramstate == RS_ERROR);
  // The current grant cycle would be the TIMEOUT-th one without a RAM response.
  assign tmo      = !ram_done && (wait_cnt == CW'(TIMEOUT - 1));
  // A grant is only live while its requester still asserts; otherwise it is an abort cycle.
  assign i_act    = (state == IGRANT) && bus.iREN;
  assign d_act    = (state == DGRANT) && d_req;
  assign i_done   = i_act && (ram_done || tmo);
  assign d_done   = d_act && (ram_done || tmo);
  assign ld_val   = (bus.ramstate == RS_ACCESS) ? bus.ramload : 32'd0;

`ifdef MEM_ARBITER_FAIR_EN
  localparam int FW = $clog2(FAIR_LIMIT + 1);
  logic [FW-1:0] fair_cnt;

  assign fair_force = (fair_cnt >= FW'(FAIR_LIMIT));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fair_cnt <= '0;
    end else if (!bus.iREN || state == IGRANT) begin
      fair_cnt <= '0;
    end else if (d_done && !fair_force) begin
      fair_cnt <= fair_cnt + FW'(1);
    end
  end
`else
  // Strict data priority: instruction is never forced ahead.
  assign fair_force = (FAIR_LIMIT < 0);
`endif

  always_comb begin
    bus.ramREN      = i_act | (d_act & bus.dREN & ~bus.dWEN);
    bus.ramWEN      = d_act & bus.dWEN;
    bus.ramaddr     = i_act ? bus.iaddr : (d_act ? bus.daddr : 32'd0);
    bus.ramstore    = d_act ? bus.dstore : 32'd0;
    bus.iload       = i_done ? ld_val : 32'd0;
    bus.dload       = d_done ? ld_val : 32'd0;
    bus.iwait       = bus.iREN & ~i_done;
    bus.dwait       = d_req & ~d_done;
    bus.timeout_err = err_q;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (bus.iREN && fair_force) state <= IGRANT;
          else if (d_req)             state <= DGRANT;
          else if (bus.iREN)          state <= IGRANT;
        end
        IGRANT: begin
          if (!bus.iREN || i_done) state <= IDLE;
          else                     wait_cnt <= wait_cnt + CW'(1);
        end
        DGRANT: begin
          if (!d_req || d_done) state <= IDLE;
          else                  wait_cnt <= wait_cnt + CW'(1);
        end
        default: state <= IDLE;
      endcase
      if ((i_done || d_done) && bus.ramstate != RS_ACCESS) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and randomized scoreboard bench for mem_arbiter
// RAM model: bit12 selects instruction space, [31:28]==E errors, [9:8] BUSY cycles before ACCESS.
module tb_mem_arbiter;
  localparam logic [31:0] IMAGIC = 32'h5A5A_C3C3;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  mem_arbiter_if bus();

  mem_arbiter dut (.CLK(CLK), .RST(RST), .bus(bus));

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_fail = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  logic        ovr_en = 1'b1;
  logic [1:0]  ovr_state = 2'd0;
  logic [31:0] ovr_load = 32'd0;
  logic [31:0] mem [16];
  logic [31:0] mem_model [16];
  int          busy_cnt = 0;

  always_comb begin
    bus.ramstate = 2'd0;
    bus.ramload  = 32'd0;
    if (ovr_en) begin
      bus.ramstate = ovr_state;
      bus.ramload  = ovr_load;
    end else if (bus.ramREN || bus.ramWEN) begin
      if (bus.ramaddr[31:28] == 4'hE) begin
        bus.ramstate = 2'd3;
      end else if (busy_cnt >= int'(bus.ramaddr[9:8])) begin
        bus.ramstate = 2'd2;
        if (bus.ramREN)
          bus.ramload = bus.ramaddr[12] ? (bus.ramaddr ^ IMAGIC) : mem[bus.ramaddr[5:2]];
      end else begin
        bus.ramstate = 2'd1;
      end
    end
  end

  always @(posedge CLK) begin
    if (RST) begin
      for (int k = 0; k < 16; k++) mem[k] <= 32'h0BAD_0000 + 32'(k);
    end else if (!ovr_en && bus.ramWEN && bus.ramstate == 2'd2) begin
      mem[bus.ramaddr[5:2]] <= bus.ramstore;
    end
    if (!(bus.ramREN || bus.ramWEN) || bus.ramstate != 2'd1) busy_cnt <= 0;
    else                                                     busy_cnt <= busy_cnt + 1;
  end

  // Scoreboard monitor: pops whenever a requester sees its completion.
  logic        sb_en = 1'b0;
  logic [31:0] iq[$];
  logic [31:0] dq[$];
  int          i_done = 0;
  int          d_done = 0;
  logic        err_exp = 1'b0;

  always @(negedge CLK) begin
    if (sb_en) begin
      if (bus.iREN && !bus.iwait) begin
        if (iq.size() == 0) check("i_unexpected", 32'(iq.size()), 32'd1);
        else                check("iload", bus.iload, iq.pop_front());
        i_done++;
      end
      if ((bus.dREN || bus.dWEN) && !bus.dwait) begin
        if (dq.size() == 0) check("d_unexpected", 32'(dq.size()), 32'd1);
        else                check("dload", bus.dload, dq.pop_front());
        d_done++;
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic smp();
    @(negedge CLK);
  endtask

  initial begin
    int g;
    int found;
    bus.iREN = 1'b0; bus.iaddr = 32'h100; bus.dREN = 1'b0; bus.dWEN = 1'b0;
    bus.daddr = 32'h200; bus.dstore = 32'd0;
    for (int k = 0; k < 16; k++) mem_model[k] = 32'h0BAD_0000 + 32'(k);

    // Reset behaviour with requests and RAM activity present
    tick();
    bus.iREN = 1'b1; bus.dREN = 1'b1; ovr_state = 2'd2; ovr_load = 32'hFFFF_FFFF;
    smp();
    check("rst_ramREN", 32'(bus.ramREN), 32'd0);
    check("rst_ramWEN", 32'(bus.ramWEN), 32'd0);
    check("rst_ramaddr", bus.ramaddr, 32'd0);
    check("rst_iload", bus.iload, 32'd0);
    check("rst_dload", bus.dload, 32'd0);
    check("rst_iwait", 32'(bus.iwait), 32'd1);
    check("rst_dwait", 32'(bus.dwait), 32'd1);
    check("rst_err", 32'(bus.timeout_err), 32'd0);
    tick();
    bus.iREN = 1'b0; bus.dREN = 1'b0; RST = 1'b0;

    // Single-cycle instruction read
    tick();
    bus.iREN = 1'b1; bus.iaddr = 32'h100; ovr_state = 2'd2; ovr_load = 32'hDEAD_BEEF;
    smp();
    check("t1_idle_ramREN", 32'(bus.ramREN), 32'd0);
    check("t1_idle_iwait", 32'(bus.iwait), 32'd1);
    check("t1_idle_iload", bus.iload, 32'd0);
    tick(); smp();
    check("t1_ramREN", 32'(bus.ramREN), 32'd1);
    check("t1_ramaddr", bus.ramaddr, 32'h100);
    check("t1_iwait", 32'(bus.iwait), 32'd0);
    check("t1_iload", bus.iload, 32'hDEAD_BEEF);
    tick();
    bus.iREN = 1'b0;

    // Data first, write wins over read, then instruction after one idle cycle
    tick();
    bus.iREN = 1'b1; bus.dWEN = 1'b1; bus.dREN = 1'b1; bus.daddr = 32'h200; bus.dstore = 32'h5;
    ovr_load = 32'h1234;
    tick(); smp();
    check("t2_ramWEN", 32'(bus.ramWEN), 32'd1);
    check("t2_ramREN", 32'(bus.ramREN), 32'd0);
    check("t2_ramaddr", bus.ramaddr, 32'h200);
    check("t2_ramstore", bus.ramstore, 32'h5);
    check("t2_dwait", 32'(bus.dwait), 32'd0);
    check("t2_iwait_d", 32'(bus.iwait), 32'd1);
    tick();
    bus.dWEN = 1'b0; bus.dREN = 1'b0;
    smp();
    check("t2_idle_ramREN", 32'(bus.ramREN), 32'd0);
    check("t2_idle_ramaddr", bus.ramaddr, 32'd0);
    tick(); smp();
    check("t2_i_ramREN", 32'(bus.ramREN), 32'd1);
    check("t2_i_ramaddr", bus.ramaddr, 32'h100);
    check("t2_iload", bus.iload, 32'h1234);
    tick();
    bus.iREN = 1'b0;

    // Abort mid-grant
    tick();
    bus.dREN = 1'b1; bus.daddr = 32'h40; ovr_state = 2'd1;
    tick(); smp();
    check("t3_ramREN", 32'(bus.ramREN), 32'd1);
    check("t3_dwait", 32'(bus.dwait), 32'd1);
    tick();
    bus.dREN = 1'b0;
    smp();
    check("t3_abort_ramREN", 32'(bus.ramREN), 32'd0);
    check("t3_abort_ramaddr", bus.ramaddr, 32'd0);
    check("t3_abort_dload", bus.dload, 32'd0);
    tick();
    bus.dREN = 1'b1; ovr_state = 2'd2; ovr_load = 32'hCAFE;
    smp();
    check("t3_idle_after_abort", 32'(bus.ramREN), 32'd0);
    tick(); smp();
    check("t3_dload", bus.dload, 32'hCAFE);
    check("t3_err", 32'(bus.timeout_err), 32'd0);
    tick();
    bus.dREN = 1'b0;

    // RAM ERROR, then a normal request
    tick();
    bus.dREN = 1'b1; bus.daddr = 32'h80; ovr_state = 2'd3; ovr_load = 32'hFFFF_FFFF;
    tick(); smp();
    check("t4_dwait", 32'(bus.dwait), 32'd0);
    check("t4_dload", bus.dload, 32'd0);
    tick();
    ovr_state = 2'd2; ovr_load = 32'h600D;
    smp();
    check("t4_err_set", 32'(bus.timeout_err), 32'd1);
    tick(); smp();
    check("t4_next_dload", bus.dload, 32'h600D);
    tick();
    bus.dREN = 1'b0;
    smp();
    check("t4_err_sticky", 32'(bus.timeout_err), 32'd1);
    tick();
    RST = 1'b1;
    #1 check("t4_err_cleared", 32'(bus.timeout_err), 32'd0);
    tick();
    RST = 1'b0;

    // Timeout with RAM stuck BUSY
    tick();
    bus.dREN = 1'b1; ovr_state = 2'd1; ovr_load = 32'h1111;
    tick();
    found = 0;
    for (int k = 1; k <= 300; k++) begin
      smp();
      if (!bus.dwait) begin
        check("t5_tmo_cycle", 32'(k), 32'd255);
        check("t5_tmo_dload", bus.dload, 32'd0);
        found = 1;
        break;
      end
      tick();
    end
    check("t5_tmo_seen", 32'(found), 32'd1);
    tick();
    bus.dREN = 1'b0;
    smp();
    check("t5_err", 32'(bus.timeout_err), 32'd1);

    // Reset in the middle of a BUSY data grant
    tick();
    bus.dREN = 1'b1;
    tick(); smp();
    check("t6_ramREN_pre", 32'(bus.ramREN), 32'd1);
    #2 RST = 1'b1;
    #1;
    check("t6_ramREN", 32'(bus.ramREN), 32'd0);
    check("t6_err", 32'(bus.timeout_err), 32'd0);
    check("t6_dwait", 32'(bus.dwait), 32'd1);
    check("t6_dload", bus.dload, 32'd0);
    tick();
    RST = 1'b0;
    tick(); smp();
    check("t6_regrant", 32'(bus.ramREN), 32'd1);
    tick();
    bus.dREN = 1'b0;

    // Continuous contention: grant pattern
    tick();
    bus.iREN = 1'b1; bus.dREN = 1'b1; ovr_state = 2'd2; ovr_load = 32'h77;
    g = 0;
    for (int c = 0; c < 200 && g < 25; c++) begin
      smp();
      if (!bus.iwait || !bus.dwait) begin
        g++;
`ifdef MEM_ARBITER_FAIR_EN
        check($sformatf("t7_grant%0d_is_instr", g), 32'(!bus.iwait), 32'((g % 5) == 0));
`else
        check($sformatf("t7_grant%0d_is_instr", g), 32'(!bus.iwait), 32'd0);
`endif
      end
    end
    check("t7_grants_seen", 32'(g), 32'd25);
    tick();
    bus.iREN = 1'b0; bus.dREN = 1'b0;

    // Randomized traffic against the RAM model and scoreboard
    RST = 1'b1;
    tick();
    RST = 1'b0; ovr_en = 1'b0; sb_en = 1'b1;
    fork
      begin : idrv
        for (int n = 0; n < 40; n++) begin
          int gap;
          int t;
          logic [31:0] a;
          gap = $urandom_range(0, 2);
          if (gap > 0) begin
            bus.iREN = 1'b0;
            repeat (gap) @(posedge CLK);
            #1;
          end
          a = ($urandom & 32'h0FFF_E3FC) | 32'h0000_1000;
          if ($urandom_range(0, 7) == 0) a[31:28] = 4'hE;
          if (a[31:28] == 4'hE) err_exp = 1'b1;
          iq.push_back((a[31:28] == 4'hE) ? 32'd0 : (a ^ IMAGIC));
          bus.iaddr = a; bus.iREN = 1'b1;
          t = 0;
          while (i_done <= n && t < 400) begin
            @(posedge CLK);
            t++;
          end
          #1;
          if (i_done <= n) begin
            check("i_timeout", 32'(i_done), 32'(n + 1));
            break;
          end
        end
        bus.iREN = 1'b0;
      end
      begin : ddrv
        for (int n = 0; n < 30; n++) begin
          int gap;
          int t;
          logic [31:0] a;
          logic        wr;
          gap = $urandom_range(0, 2);
          if (gap > 0) begin
            bus.dREN = 1'b0; bus.dWEN = 1'b0;
            repeat (gap) @(posedge CLK);
            #1;
          end
          a = $urandom & 32'h0FFF_E3FC;
          if ($urandom_range(0, 7) == 0) a[31:28] = 4'hE;
          if (a[31:28] == 4'hE) err_exp = 1'b1;
          wr = 1'($urandom_range(0, 1));
          bus.daddr = a;
          bus.dstore = $urandom;
          if (wr) begin
            bus.dWEN = 1'b1; bus.dREN = 1'($urandom_range(0, 1));
            dq.push_back(32'd0);
            if (a[31:28] != 4'hE) mem_model[a[5:2]] = bus.dstore;
          end else begin
            bus.dWEN = 1'b0; bus.dREN = 1'b1;
            dq.push_back((a[31:28] == 4'hE) ? 32'd0 : mem_model[a[5:2]]);
          end
          t = 0;
          while (d_done <= n && t < 400) begin
            @(posedge CLK);
            t++;
          end
          #1;
          if (d_done <= n) begin
            check("d_timeout", 32'(d_done), 32'(n + 1));
            break;
          end
        end
        bus.dREN = 1'b0; bus.dWEN = 1'b0;
      end
    join
    repeat (3) tick();
    sb_en = 1'b0;
    check("iq_left", 32'(iq.size()), 32'd0);
    check("dq_left", 32'(dq.size()), 32'd0);
    check("rand_err_flag", 32'(bus.timeout_err), 32'(err_exp));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
